// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the burst-fill cache controller:
// FSM state encoding, write-miss policy codes and the index-width helper.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LOOKUP,
    WR_LOOKUP,
    WR_WAIT,
    FILL_REQ,
    FILL_WAIT,
    FILL_WR,
    DONE
  } state_t;

  // Write-miss policy: plain write-through, or write-through followed by a line fill.
  localparam int WA_NONE = 0;
  localparam int WA_FILL = 1;

  // Wide enough for the largest legal WAIT_CYCLES (255).
  localparam int WAIT_CNT_W = 8;

  function automatic int idx_width(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/cache_ctrl_burst_if.sv
// Processor, tag-compare, cache-array and system-bus signals of the cache controller.
// The controller uses the slave view; the processor/bus side uses the master view.
interface cache_ctrl_burst_if #(
  parameter int LINE_WORDS = 4
);
  localparam int IDX_W = cache_ctrl_pkg::idx_width(LINE_WORDS);

  logic             p_strobe;
  logic             p_rw;
  logic             match;
  logic             valid;
  logic             p_ready;
  logic             p_data_oe;
  logic             cache_write;
  logic             cache_data_sel;
  logic [IDX_W-1:0] cache_word_idx;
  logic             valid_set;
  logic             fill_active;
  logic             sys_strobe;
  logic             sys_rw;
  logic             sys_data_oe;

  modport master (
    output p_strobe, p_rw, match, valid,
    input  p_ready, p_data_oe, cache_write, cache_data_sel, cache_word_idx,
           valid_set, fill_active, sys_strobe, sys_rw, sys_data_oe
  );

  modport slave (
    input  p_strobe, p_rw, match, valid,
    output p_ready, p_data_oe, cache_write, cache_data_sel, cache_word_idx,
           valid_set, fill_active, sys_strobe, sys_rw, sys_data_oe
  );

endinterface

// File: rtl/wait_down_counter.sv
// Loadable down counter that stops at zero; times system-bus wait states.
module wait_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  if (WIDTH < 1) begin : g_bad_width
    $error("wait_down_counter: WIDTH must be at least 1");
  end

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign value = count;
  assign zero  = (count == '0);

endmodule

// File: rtl/cache_ctrl_burst.sv
// Cache controller with write-through policy and in-order multi-word line fills;
// every system transfer is followed by WAIT_CYCLES wait states.
module cache_ctrl_burst
  import cache_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES    = 3,
  parameter int LINE_WORDS     = 4,
  parameter int WRITE_ALLOCATE = WA_NONE
) (
  input  logic             clk,
  input  logic             reset,
  cache_ctrl_burst_if.slave bus
);

  localparam int                    IDX_W     = idx_width(LINE_WORDS);
  localparam logic [IDX_W-1:0]      LAST_WORD = IDX_W'(LINE_WORDS - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 255) begin : g_bad_wait
    $error("cache_ctrl_burst: WAIT_CYCLES must be in 1..255");
  end
  if (LINE_WORDS < 1 || LINE_WORDS > 16 || (LINE_WORDS & (LINE_WORDS - 1)) != 0) begin : g_bad_line
    $error("cache_ctrl_burst: LINE_WORDS must be a power of two in 1..16");
  end
  if (WRITE_ALLOCATE != WA_NONE && WRITE_ALLOCATE != WA_FILL) begin : g_bad_policy
    $error("cache_ctrl_burst: WRITE_ALLOCATE must be WA_NONE or WA_FILL");
  end

  state_t                  state, state_next;
  logic [IDX_W-1:0]        word_cnt;
  logic                    op_write;
  logic                    miss_latched;
  logic                    cnt_load;
  logic                    cnt_dec;
  logic [WAIT_CNT_W-1:0]   wait_value;
  logic                    wait_zero;

  wire hit       = bus.match && bus.valid;
  wire word_last = (word_cnt == LAST_WORD);

  wait_down_counter #(
    .WIDTH(WAIT_CNT_W)
  ) u_wait_cnt (
    .clk       (clk),
    .reset     (reset),
    .load      (cnt_load),
    .load_value(WAIT_LOAD),
    .dec       (cnt_dec),
    .value     (wait_value),
    .zero      (wait_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      word_cnt     <= '0;
      op_write     <= 1'b0;
      miss_latched <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && bus.p_strobe) op_write <= !bus.p_rw;
      if (state == WR_LOOKUP) miss_latched <= !hit;
      // Every fill starts at word 0, whether entered from a read or a write miss.
      if ((state == RD_LOOKUP && !hit) || (state == WR_WAIT && wait_zero)) word_cnt <= '0;
      if (state == FILL_WR && !word_last) word_cnt <= word_cnt + IDX_W'(1);
    end
  end

  // NOTE: every output and next-state signal gets a default before the case,
  // so no path through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next         = state;
    cnt_load           = 1'b0;
    cnt_dec            = 1'b0;
    bus.p_ready        = 1'b0;
    bus.p_data_oe      = 1'b0;
    bus.cache_write    = 1'b0;
    bus.cache_data_sel = 1'b0;
    bus.cache_word_idx = '0;
    bus.valid_set      = 1'b0;
    bus.fill_active    = 1'b0;
    bus.sys_strobe     = 1'b0;
    bus.sys_rw         = 1'b0;
    bus.sys_data_oe    = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.p_strobe) state_next = bus.p_rw ? RD_LOOKUP : WR_LOOKUP;
      end
      RD_LOOKUP: begin
        bus.p_data_oe = 1'b1;
        if (hit) begin
          bus.p_ready = 1'b1;
          state_next  = IDLE;
        end else begin
          state_next  = FILL_REQ;
        end
      end
      FILL_REQ: begin
        bus.sys_strobe     = 1'b1;
        bus.sys_rw         = 1'b1;
        bus.fill_active    = 1'b1;
        bus.cache_word_idx = word_cnt;
        cnt_load           = 1'b1;
        state_next         = FILL_WAIT;
      end
      FILL_WAIT: begin
        bus.sys_rw         = 1'b1;
        bus.fill_active    = 1'b1;
        bus.cache_word_idx = word_cnt;
        cnt_dec            = 1'b1;
        if (wait_zero) state_next = FILL_WR;
      end
      FILL_WR: begin
        bus.cache_write    = 1'b1;
        bus.cache_data_sel = 1'b1;
        bus.fill_active    = 1'b1;
        bus.cache_word_idx = word_cnt;
        if (word_last) begin
          bus.valid_set = 1'b1;
          state_next    = DONE;
        end else begin
          state_next    = FILL_REQ;
        end
      end
      WR_LOOKUP: begin
        bus.sys_strobe  = 1'b1;
        bus.sys_data_oe = 1'b1;
        bus.cache_write = hit;
        cnt_load        = 1'b1;
        state_next      = WR_WAIT;
      end
      WR_WAIT: begin
        bus.sys_data_oe = 1'b1;
        cnt_dec         = 1'b1;
        if (wait_zero) begin
          state_next = (miss_latched && WRITE_ALLOCATE == WA_FILL) ? FILL_REQ : DONE;
        end
      end
      DONE: begin
        bus.p_ready   = 1'b1;
        bus.p_data_oe = !op_write;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The loaded count never exceeds WAIT_CYCLES-1 while waiting.
  wait_range_a: assert property (@(posedge clk) disable iff (reset)
    (state == FILL_WAIT || state == WR_WAIT) |-> (wait_value < WAIT_CNT_W'(WAIT_CYCLES)));

endmodule

// File: doc/cache_ctrl_burst.md
CACHE_CTRL_BURST -- requirements
Module: cache_ctrl_burst

Interface
REQ-001 Parameter WAIT_CYCLES, default 3, SHALL set system-bus wait states per transfer (legal 1..255).
REQ-002 Parameter LINE_WORDS, default 4, SHALL set words per cache line (power of two, 1..16).
REQ-003 Parameter WRITE_ALLOCATE, default 0, SHALL set the write-miss policy: 0 = write-through no-allocate, 1 = write-through then line fill.
REQ-004 Local parameter IDX_W = max(1, clog2(LINE_WORDS)) SHALL set the word-index width.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 p_strobe  in  1  processor request, sampled only in IDLE.
REQ-008 p_rw  in  1  1 = read, 0 = write; sampled with p_strobe.
REQ-009 match  in  1  tag compare result.
REQ-010 valid  in  1  line valid bit.
REQ-011 p_ready  out  1  processor acknowledge, one-cycle pulse.
REQ-012 p_data_oe  out  1  drive cache data onto processor bus.
REQ-013 cache_write  out  1  cache data-array write strobe.
REQ-014 cache_data_sel  out  1  cache write source: 1 = system bus, 0 = processor.
REQ-015 cache_word_idx  out  IDX_W  word index for cache write and system fetch.
REQ-016 valid_set  out  1  pulse that sets tag and valid for the current line.
REQ-017 fill_active  out  1  high while a line fill owns the address mux.
REQ-018 sys_strobe  out  1  system-bus transfer start, one-cycle pulse.
REQ-019 sys_rw  out  1  1 = system read (fill), 0 = system write.
REQ-020 sys_data_oe  out  1  drive processor write data onto the system bus.

Function
REQ-021 States SHALL be IDLE, RD_LOOKUP, WR_LOOKUP, WR_WAIT, FILL_REQ, FILL_WAIT, FILL_WR, DONE.
REQ-022 IDLE SHALL assert no outputs; p_strobe=1 goes to RD_LOOKUP if p_rw=1, else to WR_LOOKUP; an op_write flag latches !p_rw.
REQ-023 RD_LOOKUP SHALL assert p_data_oe; on hit (match&&valid) it asserts p_ready in the same cycle and goes to IDLE; on miss it goes to FILL_REQ with word_cnt=0.
REQ-024 FILL_REQ SHALL assert sys_strobe, sys_rw=1, fill_active, cache_word_idx=word_cnt, and load the wait counter with WAIT_CYCLES-1.
REQ-025 FILL_WAIT SHALL hold fill_active and sys_rw=1 and decrement the counter; it exits to FILL_WR when the counter is 0, giving exactly WAIT_CYCLES cycles.
REQ-026 FILL_WR SHALL assert cache_write, cache_data_sel=1, fill_active, and cache_word_idx=word_cnt.
REQ-027 From FILL_WR: if word_cnt=LINE_WORDS-1, assert valid_set and go to DONE; otherwise increment word_cnt and go to FILL_REQ. Words are fetched in order 0..LINE_WORDS-1 with no wrap.
REQ-028 WR_LOOKUP SHALL assert sys_strobe, sys_rw=0 and sys_data_oe, and load the wait counter with WAIT_CYCLES-1.
REQ-029 On hit in WR_LOOKUP, the block SHALL also assert cache_write with cache_data_sel=0; a miss_latched flag SHALL capture !(match&&valid).
REQ-030 WR_WAIT SHALL hold sys_data_oe and sys_rw=0 and count as in FILL_WAIT.
REQ-031 At WR_WAIT count 0, the block SHALL go to FILL_REQ if miss_latched and WRITE_ALLOCATE=1, else to DONE.
REQ-032 DONE SHALL assert p_ready and set p_data_oe=!op_write, then go to IDLE.
REQ-033 Latency SHALL be as follows, in cycles after the strobe-sampling IDLE cycle: read hit acks at 1; read miss at 2+LINE_WORDS*(WAIT_CYCLES+2); write without fill at WAIT_CYCLES+2; write-allocate miss at WAIT_CYCLES+2+LINE_WORDS*(WAIT_CYCLES+2).
REQ-034 p_strobe outside IDLE SHALL be ignored; match and valid are used only in the LOOKUP states.
REQ-035 All outputs SHALL be decoded from state and counters with no combinational path from p_strobe; p_ready depends only on match and valid in RD_LOOKUP.
REQ-036 sys_rw SHALL be 0 whenever no system transfer is in progress.

Reset
REQ-037 reset=1 SHALL force IDLE and clear word_cnt, the wait counter, op_write and miss_latched.
REQ-038 All outputs SHALL be 0 in the cycle after reset is sampled, including when reset occurs mid-fill or mid-write.
REQ-039 A partial fill aborted by reset SHALL never assert valid_set.

Structure
REQ-040 State encoding and the policy constants WA_NONE and WA_FILL SHALL live in the shared package cache_ctrl_pkg.
REQ-041 The wait counter SHALL be one sub-module, wait_down_counter, parametrised by width, with load, value and zero outputs.
REQ-042 Illegal parameter values SHALL trigger an elaboration-time error.

Verification (WAIT_CYCLES=2, LINE_WORDS=4)
REQ-043 Read hit: strobe with p_rw=1 at cycle 0, match=valid=1 -> p_ready and p_data_oe at cycle 1, IDLE at cycle 2.
REQ-044 Read miss: match=0 -> 4 sys_strobe pulses at cycles 2,6,10,14; cache_write at cycles 5,9,13,17 with idx 0..3; valid_set at cycle 17; p_ready at cycle 18.
REQ-045 Write hit, WRITE_ALLOCATE=0 -> cache_write, sys_strobe and sys_data_oe at cycle 1; p_ready at cycle 4 with p_data_oe=0.
REQ-046 Write miss, WRITE_ALLOCATE=1 -> no cache_write at cycle 1; fill sys_strobes at cycles 4,8,12,16; p_ready at cycle 20.
REQ-047 Reset asserted at cycle 8 of a read miss -> all outputs 0 at cycle 9, no valid_set, and a new read hit afterwards acks in 1 cycle.
REQ-048 A p_strobe pulse during FILL_WAIT -> ignored; exactly one p_ready per accepted request.
